// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared defaults and state encoding for the SDRAM port arbiter
package sdram_arb_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int ADDR_W_DEF = 24;
  localparam int LEN_W_DEF  = 10;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t S_IDLE = 2'd0;
  localparam arb_state_t S_REQ  = 2'd1;
  localparam arb_state_t S_XFER = 2'd2;
  localparam arb_state_t S_DONE = 2'd3;

endpackage

// File: rtl/sdram_addr_gen.sv
// rtl/sdram_addr_gen.sv - one channel's burst address register with reload and wrap
module sdram_addr_gen import sdram_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              owner,
  input  logic              done,
  input  logic [ADDR_W-1:0] min_addr,
  input  logic [ADDR_W-1:0] max_addr,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr
);

  logic              load_pend;
  logic [ADDR_W:0]   next_addr;
  logic [ADDR_W+1:0] next_end;
  logic              wrap;

  assign next_addr = {1'b0, addr} + (ADDR_W+1)'(len);
  // next > max - len, rearranged so a length larger than max cannot underflow
  assign next_end  = (ADDR_W+2)'(next_addr) + (ADDR_W+2)'(len);
  assign wrap      = next_end > (ADDR_W+2)'(max_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= min_addr;
      load_pend <= 1'b0;
    end else if (done) begin
      if (load_pend || load || wrap)
        addr <= min_addr;
      else
        addr <= next_addr[ADDR_W-1:0];
      load_pend <= 1'b0;
    end else if (load) begin
      // the owner's burst address must stay put until the burst completes
      if (owner)
        load_pend <= 1'b1;
      else
        addr <= min_addr;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin arbiter of user channels onto one SDRAM controller
// Define SDRAM_ARB_PRIO_EN to give channel 0 absolute priority in arbitration.
module sdram_port_arbiter import sdram_arb_pkg::*; #(
  parameter int                NUM_CH  = NUM_CH_DEF,
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter int                LEN_W   = LEN_W_DEF,
  parameter logic [NUM_CH-1:0] WR_MASK = NUM_CH'(4'b0011)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sdram_init_done,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_load,
  input  logic [NUM_CH*ADDR_W-1:0] ch_min_addr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_max_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  output logic                     sdram_wr_req,
  output logic                     sdram_rd_req,
  input  logic                     sdram_wr_ack,
  input  logic                     sdram_rd_ack,
  output logic [ADDR_W-1:0]        sdram_addr_o,
  output logic [LEN_W-1:0]         sdram_len_o,
  output logic [NUM_CH-1:0]        ch_grant,
  output logic [NUM_CH-1:0]        ch_ack
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_t        state;
  logic [NUM_CH-1:0] grant_q;
  logic [NUM_CH-1:0] eligible;
  logic [CH_W-1:0]   owner;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   pick;
  logic              found;
  logic              match_ack;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] ch_addr [NUM_CH];
  logic [LEN_W-1:0]  len_a   [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign len_a[g]    = ch_len[g*LEN_W +: LEN_W];
    assign eligible[g] = ch_req[g] && (len_a[g] != '0);

    sdram_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
    ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (ch_load[g]),
      .owner    (grant_q[g]),
      .done     ((state == S_DONE) && grant_q[g]),
      .min_addr (ch_min_addr[g*ADDR_W +: ADDR_W]),
      .max_addr (ch_max_addr[g*ADDR_W +: ADDR_W]),
      .len      (len_a[g]),
      .addr     (ch_addr[g])
    );
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!found && eligible[(int'(last_grant) + i) % NUM_CH]) begin
        found = 1'b1;
        pick  = CH_W'((int'(last_grant) + i) % NUM_CH);
      end
    end
`ifdef SDRAM_ARB_PRIO_EN
    if (eligible[0])
      pick = '0;
`endif
  end

  assign match_ack = WR_MASK[owner] ? sdram_wr_ack : sdram_rd_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant_q    <= '0;
      owner      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      addr_q     <= '0;
      len_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sdram_init_done && (|eligible)) begin
            grant_q <= NUM_CH'(1) << pick;
            owner   <= pick;
            addr_q  <= ch_addr[pick];
            len_q   <= len_a[pick];
            state   <= S_REQ;
          end
        end
        S_REQ:  if (match_ack)  state <= S_XFER;
        S_XFER: if (!match_ack) state <= S_DONE;
        default: begin
`ifdef SDRAM_ARB_PRIO_EN
          // priority wins by channel 0 leave the round-robin pointer alone
          if (owner != '0)
            last_grant <= owner;
`else
          last_grant <= owner;
`endif
          grant_q <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // outputs are forced low for every cycle rst is high, not just after the edge
  assign sdram_wr_req = !rst && (state == S_REQ) && WR_MASK[owner];
  assign sdram_rd_req = !rst && (state == S_REQ) && !WR_MASK[owner];
  assign ch_ack       = (!rst && (state == S_XFER) && match_ack) ? grant_q : '0;
  assign ch_grant     = rst ? '0 : grant_q;
  assign sdram_addr_o = rst ? '0 : addr_q;
  assign sdram_len_o  = rst ? '0 : len_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - randomized self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 24;
  localparam int LEN_W  = 10;
  localparam logic [NUM_CH-1:0] WR_MASK = 4'b0011;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     sdram_init_done;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_load;
  logic [NUM_CH*ADDR_W-1:0] ch_min_addr;
  logic [NUM_CH*ADDR_W-1:0] ch_max_addr;
  logic [NUM_CH*LEN_W-1:0]  ch_len;
  logic                     sdram_wr_req;
  logic                     sdram_rd_req;
  logic                     sdram_wr_ack;
  logic                     sdram_rd_ack;
  logic [ADDR_W-1:0]        sdram_addr_o;
  logic [LEN_W-1:0]         sdram_len_o;
  logic [NUM_CH-1:0]        ch_grant;
  logic [NUM_CH-1:0]        ch_ack;

  logic [ADDR_W-1:0] min_a  [NUM_CH];
  logic [ADDR_W-1:0] max_a  [NUM_CH];
  logic [ADDR_W-1:0] base_a [NUM_CH];
  logic [LEN_W-1:0]  len_a  [NUM_CH];

  longint m_addr [NUM_CH];
  int     m_last;
  bit     m_pend;

  int n_pass   = 0;
  int n_checks = 0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign ch_min_addr[g*ADDR_W +: ADDR_W] = min_a[g];
    assign ch_max_addr[g*ADDR_W +: ADDR_W] = max_a[g];
    assign ch_len[g*LEN_W +: LEN_W]        = len_a[g];
  end

  sdram_port_arbiter #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .WR_MASK (WR_MASK)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sdram_init_done (sdram_init_done),
    .ch_req          (ch_req),
    .ch_load         (ch_load),
    .ch_min_addr     (ch_min_addr),
    .ch_max_addr     (ch_max_addr),
    .ch_len          (ch_len),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_rd_req    (sdram_rd_req),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_addr_o    (sdram_addr_o),
    .sdram_len_o     (sdram_len_o),
    .ch_grant        (ch_grant),
    .ch_ack          (ch_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick();
    logic [NUM_CH-1:0] el;
    if (!sdram_init_done) return -1;
    for (int c = 0; c < NUM_CH; c++) el[c] = ch_req[c] && (len_a[c] != 0);
`ifdef SDRAM_ARB_PRIO_EN
    if (el[0]) return 0;
`endif
    for (int k = 1; k <= NUM_CH; k++)
      if (el[(m_last + k) % NUM_CH]) return (m_last + k) % NUM_CH;
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) m_addr[c] = longint'(min_a[c]);
    m_last = NUM_CH - 1;
    m_pend = 1'b0;
  endtask

  task automatic model_advance(input int c);
    longint nxt;
    nxt = m_addr[c] + longint'(len_a[c]);
    if (m_pend || nxt > longint'(max_a[c]) - longint'(len_a[c]))
      m_addr[c] = longint'(min_a[c]);
    else
      m_addr[c] = nxt;
    m_pend = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({ch_grant, ch_ack, sdram_wr_req, sdram_rd_req}), 32'd0);
    check({tag, "_addr"}, 32'(sdram_addr_o), 32'd0);
    check({tag, "_len"}, 32'(sdram_len_o), 32'd0);
  endtask

  // One arbitration edge plus, if something wins, the whole burst acting as the controller.
  task automatic run_burst(input int load_ch, input bit rst_mid);
    int   exp_ch;
    int   d;
    int   l;
    logic exp_wr;
    exp_ch = model_pick();
    m_pend = 1'b0;
    tick();
    if (exp_ch < 0) begin
      check("no_grant", 32'(ch_grant), 32'd0);
      check("no_req", 32'({sdram_wr_req, sdram_rd_req}), 32'd0);
      return;
    end
    exp_wr = WR_MASK[exp_ch];
    check("grant", 32'(ch_grant), 32'(1) << exp_ch);
    check("req", 32'({sdram_wr_req, sdram_rd_req}), exp_wr ? 32'd2 : 32'd1);
    check("addr", 32'(sdram_addr_o), 32'(m_addr[exp_ch]));
    check("len", 32'(sdram_len_o), 32'(len_a[exp_ch]));
    if ($urandom_range(0, 1) == 1) ch_req = '0;
    d = $urandom_range(0, 3);
    repeat (d) begin
      tick();
      check("req_hold", 32'({sdram_wr_req, sdram_rd_req}), exp_wr ? 32'd2 : 32'd1);
    end
    if (exp_wr) sdram_wr_ack = 1'b1;
    else        sdram_rd_ack = 1'b1;
    l = $urandom_range(2, 5);
    for (int i = 0; i < l; i++) begin
      tick();
      check("xfer_req", 32'({sdram_wr_req, sdram_rd_req}), 32'd0);
      check("ch_ack", 32'(ch_ack), 32'(1) << exp_ch);
      if (i == 0) check("addr_hold", 32'(sdram_addr_o), 32'(m_addr[exp_ch]));
      if (i == 0 && rst_mid) begin
        rst = 1'b1;
        #1;
        check_all_zero("rst_now");
        tick();
        check_all_zero("rst_next");
        rst          = 1'b0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        ch_req       = '0;
        model_reset();
        tick();
        check("post_rst_idle", 32'({ch_grant, sdram_wr_req, sdram_rd_req}), 32'd0);
        return;
      end
      if (i == 0 && load_ch >= 0) begin
        ch_load = NUM_CH'(1) << load_ch;
        if (load_ch == exp_ch) m_pend = 1'b1;
        else                   m_addr[load_ch] = longint'(min_a[load_ch]);
      end else begin
        ch_load = '0;
      end
    end
    ch_load      = '0;
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    #1;
    check("ack_drop", 32'(ch_ack), 32'd0);
    tick();
    check("done_grant", 32'(ch_grant), 32'(1) << exp_ch);
    check("done_req", 32'({sdram_wr_req, sdram_rd_req}), 32'd0);
    tick();
    check("idle_grant", 32'(ch_grant), 32'd0);
    model_advance(exp_ch);
`ifdef SDRAM_ARB_PRIO_EN
    if (exp_ch != 0) m_last = exp_ch;
`else
    m_last = exp_ch;
`endif
  endtask

  initial begin
    int lc;
    rst             = 1'b1;
    sdram_init_done = 1'b1;
    ch_req          = '0;
    ch_load         = '0;
    sdram_wr_ack    = 1'b0;
    sdram_rd_ack    = 1'b0;
    base_a = '{24'h0, 24'h1000, 24'h4000, 24'h8000};
    min_a  = '{24'h0, 24'h0, 24'h4000, 24'h8000};
    max_a  = '{24'd1024, 24'h2000, 24'h4800, 24'h8400};
    len_a  = '{10'd256, 10'd256, 10'd256, 10'd256};

    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();

    // channel 0 alone: 0, 256, 512, 768 then wrap to 0
    for (int i = 0; i < 5; i++) begin
      ch_req = 4'b0001;
      run_burst(-1, 1'b0);
    end

    // all channels: round robin, writes on 0/1 and reads on 2/3
    for (int i = 0; i < 5; i++) begin
      ch_req = 4'b1111;
      run_burst(-1, 1'b0);
    end

    // reload of the owner mid-burst takes the new minimum on the next burst
    ch_req = 4'b0010;
    run_burst(-1, 1'b0);
    min_a[1] = 24'h1000;
    ch_req = 4'b0010;
    run_burst(1, 1'b0);
    ch_req = 4'b0010;
    run_burst(-1, 1'b0);

    // reset in the middle of a transfer
    ch_req = 4'b0100;
    run_burst(-1, 1'b1);

    // no grants until the controller reports init done, then channel 0 first
    sdram_init_done = 1'b0;
    ch_req = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("init_block", 32'({ch_grant, sdram_wr_req, sdram_rd_req}), 32'd0);
    end
    sdram_init_done = 1'b1;
    run_burst(-1, 1'b0);

`ifdef SDRAM_ARB_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      ch_req = 4'b1111;
      run_burst(-1, 1'b0);
    end
`endif

    for (int it = 0; it < 60; it++) begin
      ch_req = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      if ($urandom_range(0, 3) == 0) begin
        lc = $urandom_range(0, NUM_CH - 1);
        case ($urandom_range(0, 4))
          0:       len_a[lc] = 10'd0;
          1:       len_a[lc] = 10'd64;
          2:       len_a[lc] = 10'd128;
          3:       len_a[lc] = 10'd300;
          default: len_a[lc] = 10'd256;
        endcase
      end
      lc = -1;
      if ($urandom_range(0, 2) == 0) begin
        lc = $urandom_range(0, NUM_CH - 1);
        min_a[lc] = base_a[lc] + ADDR_W'(64 * $urandom_range(0, 4));
      end
      run_burst(lc, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
